// File: rtl/dmem_io_pkg.sv
// Shared constants for the dmem_io_multi data-memory / I/O block:
// parameter defaults, I/O register offsets and the 7-segment decode.
package dmem_io_pkg;

  localparam int          DATA_W_DEF          = 16;
  localparam int          ADDR_W_DEF          = 16;
  localparam int          DEPTH_DEF           = 128;
  localparam int          NUM_SW_DEF          = 2;
  localparam int          NUM_DISP_DEF        = 1;
  localparam int unsigned IO_BASE_DEF         = 32'hFFF0;
  localparam int          DEBOUNCE_CYCLES_DEF = 4;

  // Word offsets of the I/O registers relative to IO_BASE.
  localparam int OFS_SW    = 0;
  localparam int OFS_DISP0 = 1;
  localparam int OFS_TIMER = 8;

  // Hex digit to segments; bit 0 = a ... bit 6 = g, active-high.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: two-flop synchroniser followed by an optional debounce
// filter. The filter is built only when DMEM_IO_DEBOUNCE_EN is defined;
// otherwise the filtered bit is the synchroniser output.
module sw_debounce
  import dmem_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic sw_async,
  output logic sw_filt
);

  logic sync1;
  logic sync2;

  // Two-flop synchroniser for the asynchronous switch input.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sw_async;
      sync2 <= sync1;
    end
  end

`ifdef DMEM_IO_DEBOUNCE_EN
  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] cnt;
  logic       filt_q;

  // Count consecutive cycles the synchronised bit differs from the filtered
  // bit; accept the new value on the DEBOUNCE_CYCLES-th one, any glitch back
  // to the old value restarts the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= 8'd0;
      filt_q <= 1'b0;
    end else if (sync2 == filt_q) begin
      cnt <= 8'd0;
    end else if (cnt == LAST) begin
      filt_q <= sync2;
      cnt    <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign sw_filt = filt_q;
`else
  // DEBOUNCE_CYCLES has no effect without the filter; pass the bit through.
  if (DEBOUNCE_CYCLES >= 0) begin : g_pass
    assign sw_filt = sync2;
  end
`endif

endmodule

// File: rtl/dmem_io_multi.sv
// Data memory with memory-mapped I/O for a single-cycle CPU: RAM at
// [0, DEPTH), filtered switches, hex 7-segment displays and a free-running
// timer. Define DMEM_IO_DEBOUNCE_EN to add per-bit switch debouncing.
//
// Bus semantics: there is no stall. dwrite commits at the rising edge of the
// cycle it is high; dread returns drdata combinationally in the same cycle
// (pre-edge contents, so read-during-write sees the old value), and drdata is
// zero whenever dread is low or the address is unmapped.
module dmem_io_multi
  import dmem_io_pkg::*;
#(
  parameter int          DATA_W          = DATA_W_DEF,
  parameter int          ADDR_W          = ADDR_W_DEF,
  parameter int          DEPTH           = DEPTH_DEF,
  parameter int          NUM_SW          = NUM_SW_DEF,
  parameter int          NUM_DISP        = NUM_DISP_DEF,
  parameter int unsigned IO_BASE         = IO_BASE_DEF,
  parameter int          DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     draddr,
  input  logic [DATA_W-1:0]     dwdata,
  input  logic                  dwrite,
  input  logic                  dread,
  input  logic [NUM_SW-1:0]     io_sw,
  output logic [DATA_W-1:0]     drdata,
  output logic [7*NUM_DISP-1:0] io_display
);

  localparam int              IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] SW_ADDR    = ADDR_W'(IO_BASE + OFS_SW);
  localparam logic [ADDR_W-1:0] TIMER_ADDR = ADDR_W'(IO_BASE + OFS_TIMER);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] timer_q;
  logic [4:0]        disp_q [NUM_DISP];
  logic [4:0]        disp_d [NUM_DISP];
  logic [6:0]        seg_q  [NUM_DISP];
  logic [NUM_SW-1:0] sw_filt;

  logic             ram_hit;
  logic             timer_hit;
  logic [IDX_W-1:0] ram_idx;

  assign ram_hit   = (draddr < ADDR_W'(DEPTH));
  assign timer_hit = (draddr == TIMER_ADDR);
  assign ram_idx   = draddr[IDX_W-1:0];

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw (
      .clock   (clock),
      .reset   (reset),
      .sw_async(io_sw[i]),
      .sw_filt (sw_filt[i])
    );
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (dwrite && ram_hit) begin
      mem[ram_idx] <= dwdata;
    end
  end

  // Free-running timer; a write of any value clears it, taking priority.
  always_ff @(posedge clock) begin
    if (reset || (dwrite && timer_hit)) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + DATA_W'(1);
    end
  end

  // Next value of each display digit register (5 bits: blank + hex digit).
  always_comb begin
    for (int k = 0; k < NUM_DISP; k++) begin
      disp_d[k] = disp_q[k];
      if (dwrite && (draddr == ADDR_W'(IO_BASE + OFS_DISP0 + k))) begin
        disp_d[k] = dwdata[4:0];
      end
    end
  end

  // Display registers and their registered segment decode, updated together
  // so the segments follow the stored digit from the cycle after the write.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_DISP; k++) begin
      if (reset) begin
        disp_q[k] <= 5'd0;
        seg_q[k]  <= seg7(4'h0);
      end else begin
        disp_q[k] <= disp_d[k];
        seg_q[k]  <= disp_d[k][4] ? 7'b0000000 : seg7(disp_d[k][3:0]);
      end
    end
  end

  for (genvar k = 0; k < NUM_DISP; k++) begin : g_disp_out
    assign io_display[7*k +: 7] = seg_q[k];
  end

  // Zero-latency read mux.
  always_comb begin
    drdata = '0;
    if (dread) begin
      if (ram_hit) begin
        drdata = mem[ram_idx];
      end else if (draddr == SW_ADDR) begin
        drdata = DATA_W'(sw_filt);
      end else if (timer_hit) begin
        drdata = timer_q;
      end else begin
        for (int k = 0; k < NUM_DISP; k++) begin
          if (draddr == ADDR_W'(IO_BASE + OFS_DISP0 + k)) begin
            drdata = DATA_W'(disp_q[k]);
          end
        end
      end
    end
  end

endmodule
